// File: rtl/vga_pkg.sv
// Shared constants for the VGA text-overlay path: glyph geometry, text grid size,
// and the bus widths used for pixel counters and colour.
package vga_pkg;
  localparam int CHAR_W    = 8;
  localparam int CHAR_H    = 16;
  localparam int TEXT_COLS = 16;
  localparam int TEXT_ROWS = 16;
  localparam int HV_W      = 11;
  localparam int RGB_W     = 12;
  localparam int TIMING_W  = 2 * HV_W + 4;
endpackage

// File: rtl/draw_rect_char_delay.sv
// Generic N-stage, WIDTH-bit register chain with synchronous active-high reset.
module delay #(
  parameter int WIDTH = 1,
  parameter int N     = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage [N];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) stage[i] <= '0;
    end else begin
      stage[0] <= din;
      for (int i = 1; i < N; i++) stage[i] <= stage[i-1];
    end
  end

  assign dout = stage[N-1];

endmodule

// File: rtl/draw_rect_char.sv
// Text overlay for the 16x16 character box: drives char/font ROM addresses,
// then paints set glyph bits over the background with a fixed 2-pclk latency.
module draw_rect_char
  import vga_pkg::*;
#(
  parameter logic [HV_W-1:0]  XPOS       = 11'd48,
  parameter logic [HV_W-1:0]  YPOS       = 11'd64,
  parameter logic [RGB_W-1:0] TEXT_COLOR = 12'hFFF
) (
  input  logic             pclk,
  input  logic             rst,
  input  logic             en,
  input  logic [HV_W-1:0]  hcount_in,
  input  logic             hsync_in,
  input  logic             hblnk_in,
  input  logic [HV_W-1:0]  vcount_in,
  input  logic             vsync_in,
  input  logic             vblnk_in,
  input  logic [RGB_W-1:0] rgb_in,
  input  logic [7:0]       char_pixels,
  output logic [7:0]       char_yx,
  output logic [3:0]       char_line,
  output logic [HV_W-1:0]  hcount_out,
  output logic             hsync_out,
  output logic             hblnk_out,
  output logic [HV_W-1:0]  vcount_out,
  output logic             vsync_out,
  output logic             vblnk_out,
  output logic [RGB_W-1:0] rgb_out
);

  localparam int XBITS = $clog2(TEXT_COLS * CHAR_W);
  localparam int YBITS = $clog2(TEXT_ROWS * CHAR_H);
  localparam int SBITS = $clog2(CHAR_W);
  localparam logic [HV_W-1:0] X_END = XPOS + HV_W'(TEXT_COLS * CHAR_W);
  localparam logic [HV_W-1:0] Y_END = YPOS + HV_W'(TEXT_ROWS * CHAR_H);

  // Only the low bits of the offsets address the box; wrap outside it is gated by in_box.
  logic [XBITS-1:0] rel_x;
  logic [YBITS-1:0] rel_y;
  logic             in_box;

  assign rel_x  = hcount_in[XBITS-1:0] - XPOS[XBITS-1:0];
  assign rel_y  = vcount_in[YBITS-1:0] - YPOS[YBITS-1:0];
  assign in_box = (hcount_in >= XPOS) && (hcount_in < X_END) &&
                  (vcount_in >= YPOS) && (vcount_in < Y_END);

  assign char_yx   = in_box ? {rel_y[YBITS-1 -: 4], rel_x[XBITS-1 -: 4]} : 8'h00;
  assign char_line = in_box ? rel_y[3:0] : 4'h0;

  logic [RGB_W-1:0] rgb_d1;
  logic             en_d1;
  logic             in_box_d1;
  logic [SBITS-1:0] bitsel_d1;
  logic             hblnk_d1;
  logic             vblnk_d1;
  logic             pix;

  always_ff @(posedge pclk) begin
    if (rst) begin
      rgb_d1    <= '0;
      en_d1     <= 1'b0;
      in_box_d1 <= 1'b0;
      bitsel_d1 <= '0;
      hblnk_d1  <= 1'b0;
      vblnk_d1  <= 1'b0;
    end else begin
      rgb_d1    <= rgb_in;
      en_d1     <= en;
      in_box_d1 <= in_box;
      bitsel_d1 <= rel_x[SBITS-1:0];
      hblnk_d1  <= hblnk_in;
      vblnk_d1  <= vblnk_in;
    end
  end

  assign pix = char_pixels[3'd7 - bitsel_d1];

  always_ff @(posedge pclk) begin
    if (rst)                            rgb_out <= '0;
    else if (hblnk_d1 || vblnk_d1)      rgb_out <= '0;
    else if (en_d1 && in_box_d1 && pix) rgb_out <= TEXT_COLOR;
    else                                rgb_out <= rgb_d1;
  end

  delay #(
    .WIDTH(TIMING_W),
    .N    (2)
  ) u_timing_delay (
    .clk (pclk),
    .rst (rst),
    .din ({hcount_in, hsync_in, hblnk_in, vcount_in, vsync_in, vblnk_in}),
    .dout({hcount_out, hsync_out, hblnk_out, vcount_out, vsync_out, vblnk_out})
  );

endmodule

// File: tb/tb_draw_rect_char.sv
// Bench for draw_rect_char: fixed vector table plus a glyph-ROM reference model
// driven by a full-line sweep and randomized pixels with occasional resets.
module tb_draw_rect_char;

  logic        pclk = 1'b0;
  logic        rst;
  logic        en;
  logic [10:0] hcount_in, vcount_in;
  logic        hsync_in, hblnk_in, vsync_in, vblnk_in;
  logic [11:0] rgb_in;
  logic [7:0]  char_pixels;
  logic [7:0]  char_yx;
  logic [3:0]  char_line;
  logic [10:0] hcount_out, vcount_out;
  logic        hsync_out, hblnk_out, vsync_out, vblnk_out;
  logic [11:0] rgb_out;

  always #5 pclk = ~pclk;

  draw_rect_char dut (
    .pclk       (pclk),
    .rst        (rst),
    .en         (en),
    .hcount_in  (hcount_in),
    .hsync_in   (hsync_in),
    .hblnk_in   (hblnk_in),
    .vcount_in  (vcount_in),
    .vsync_in   (vsync_in),
    .vblnk_in   (vblnk_in),
    .rgb_in     (rgb_in),
    .char_pixels(char_pixels),
    .char_yx    (char_yx),
    .char_line  (char_line),
    .hcount_out (hcount_out),
    .hsync_out  (hsync_out),
    .hblnk_out  (hblnk_out),
    .vcount_out (vcount_out),
    .vsync_out  (vsync_out),
    .vblnk_out  (vblnk_out),
    .rgb_out    (rgb_out)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic drive(input logic [10:0] h, input logic [10:0] v, input logic hs, input logic hb,
                       input logic vs, input logic vb, input logic e, input logic [11:0] c,
                       input logic [7:0] px);
    hcount_in = h; vcount_in = v; hsync_in = hs; hblnk_in = hb;
    vsync_in = vs; vblnk_in = vb; en = e; rgb_in = c; char_pixels = px;
  endtask

  // ---------------- fixed vectors ----------------
  typedef struct {
    logic [10:0] h;
    logic [10:0] v;
    logic        hb;
    logic        vb;
    logic        en;
    logic [11:0] rgb;
    logic [7:0]  px;
    logic [7:0]  e_yx;
    logic [3:0]  e_line;
    logic [11:0] e_rgb;
  } vec_t;

  vec_t vecs [11];

  // ---------------- reference model ----------------
  typedef struct {
    logic [10:0] h;
    logic        hs;
    logic        hb;
    logic [10:0] v;
    logic        vs;
    logic        vb;
    logic [11:0] rgb;
  } out_t;

  logic [7:0]  rom [4096];
  out_t        q [$];
  logic [11:0] prev_idx;

  task automatic cycle(input logic r, input logic [10:0] h, input logic [10:0] v,
                       input logic hs, input logic hb, input logic vs, input logic vb,
                       input logic e, input logic [11:0] c);
    int rx, ry;
    bit inb;
    logic [7:0] eyx;
    logic [3:0] eln;
    out_t o, got;
    rst = r;
    drive(h, v, hs, hb, vs, vb, e, c, rom[prev_idx]);
    rx  = int'(h) - 48;
    ry  = int'(v) - 64;
    inb = (rx >= 0) && (rx < 128) && (ry >= 0) && (ry < 256);
    eyx = inb ? 8'((ry / 16) * 16 + rx / 8) : 8'h00;
    eln = inb ? 4'(ry % 16) : 4'h0;
    #1;
    check("char_yx", char_yx, eyx);
    check("char_line", char_line, eln);
    o.h = h; o.hs = hs; o.hb = hb; o.v = v; o.vs = vs; o.vb = vb;
    if (hb || vb) o.rgb = 12'h000;
    else if (inb && e && rom[{eyx, eln}][7 - (rx % 8)]) o.rgb = 12'hFFF;
    else o.rgb = c;
    if (r) begin
      o = '{default: '0};
      if (q.size() > 0) q[q.size()-1] = '{default: '0};
    end
    q.push_back(o);
    prev_idx = {eyx, eln};
    @(negedge pclk);
    if (q.size() == 3) begin
      got = q.pop_front();
      check("timing", {hcount_out, hsync_out, hblnk_out, vcount_out, vsync_out, vblnk_out},
                      {got.h, got.hs, got.hb, got.v, got.vs, got.vb});
      check("rgb_out", rgb_out, got.rgb);
    end
    @(posedge pclk); #1;
  endtask

  task automatic rand_cycle(input logic r);
    cycle(r, 11'($urandom_range(30, 200)), 11'($urandom_range(50, 340)),
          1'($urandom), ($urandom % 8) == 0, 1'($urandom), ($urandom % 10) == 0,
          ($urandom % 4) != 0, 12'($urandom));
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) rom[i] = 8'($urandom);
    prev_idx = '0;

    vecs[0]  = '{11'd48,  11'd64,  1'b0, 1'b0, 1'b1, 12'h0A0, 8'h80, 8'h00, 4'h0, 12'hFFF};
    vecs[1]  = '{11'd91,  11'd103, 1'b0, 1'b0, 1'b1, 12'h123, 8'h10, 8'h25, 4'h7, 12'hFFF};
    vecs[2]  = '{11'd91,  11'd103, 1'b0, 1'b0, 1'b1, 12'h123, 8'hEF, 8'h25, 4'h7, 12'h123};
    vecs[3]  = '{11'd47,  11'd100, 1'b0, 1'b0, 1'b1, 12'h456, 8'hFF, 8'h00, 4'h0, 12'h456};
    vecs[4]  = '{11'd176, 11'd100, 1'b0, 1'b0, 1'b1, 12'h789, 8'hFF, 8'h00, 4'h0, 12'h789};
    vecs[5]  = '{11'd48,  11'd64,  1'b1, 1'b0, 1'b1, 12'h0AB, 8'h80, 8'h00, 4'h0, 12'h000};
    vecs[6]  = '{11'd48,  11'd64,  1'b0, 1'b1, 1'b1, 12'h0AB, 8'h80, 8'h00, 4'h0, 12'h000};
    vecs[7]  = '{11'd48,  11'd64,  1'b0, 1'b0, 1'b0, 12'h0AB, 8'h80, 8'h00, 4'h0, 12'h0AB};
    vecs[8]  = '{11'd175, 11'd319, 1'b0, 1'b0, 1'b1, 12'h321, 8'h01, 8'hFF, 4'hF, 12'hFFF};
    vecs[9]  = '{11'd100, 11'd320, 1'b0, 1'b0, 1'b1, 12'h654, 8'hFF, 8'h00, 4'h0, 12'h654};
    vecs[10] = '{11'd100, 11'd63,  1'b0, 1'b0, 1'b1, 12'h987, 8'hFF, 8'h00, 4'h0, 12'h987};

    rst = 1'b1;
    drive(11'd0, 11'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 8'h00);
    @(posedge pclk); #1;

    // Reset with arbitrary inputs, then random traffic through the model.
    for (int i = 0; i < 3; i++) rand_cycle(1'b1);
    for (int i = 0; i < 20; i++) rand_cycle(1'b0);

    // Fixed vectors: each applied alone, glyph row supplied one pclk later.
    rst = 1'b0;
    for (int i = 0; i < 11; i++) begin
      drive(vecs[i].h, vecs[i].v, 1'b0, vecs[i].hb, 1'b0, vecs[i].vb, vecs[i].en, vecs[i].rgb, 8'h00);
      #1;
      check($sformatf("vec%0d_yx", i), char_yx, vecs[i].e_yx);
      check($sformatf("vec%0d_line", i), char_line, vecs[i].e_line);
      @(posedge pclk); #1;
      drive(11'd0, 11'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000, vecs[i].px);
      @(posedge pclk); #1;
      drive(11'd0, 11'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 8'h00);
      @(negedge pclk);
      check($sformatf("vec%0d_rgb", i), rgb_out, vecs[i].e_rgb);
      check($sformatf("vec%0d_hcount", i), hcount_out, vecs[i].h);
      @(posedge pclk); #1;
    end

    // Full line at the top row of the box with real-looking sync/blank timing.
    q.delete();
    prev_idx = '0;
    for (int h = 0; h < 1056; h++)
      cycle(1'b0, 11'(h), 11'd64, (h >= 840) && (h < 968), h >= 800, 1'b0, 1'b0, 1'b1, 12'($urandom));

    // Random pixels with a hand-placed mid-stream reset and sporadic random resets.
    for (int i = 0; i < 200; i++) rand_cycle(1'b0);
    rand_cycle(1'b1);
    for (int i = 0; i < 5; i++) rand_cycle(1'b0);
    for (int i = 0; i < 400; i++) rand_cycle(($urandom % 60) == 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/draw_rect_char.md
Name: draw_rect_char

Overview:
- Text-overlay stage for the 16x16 character box. It sits directly downstream of the VGA timing/background chain and upstream of the output register.
- Generates the character-cell address for char_rom_16x16 and the glyph row index for the font ROM (8x16 glyphs).
- Receives the glyph row bits back and paints text pixels over rgb_in.
- Passes all timing signals through, delayed to match its own pipeline latency.

Parameters:
- XPOS, 48, left edge of text box in pixels.
- YPOS, 64, top edge of text box in pixels.
- TEXT_COLOR, 12'hFFF, RGB444 colour of set glyph pixels.

Ports:
- pclk  in  1  pixel clock; sole clock.
- rst  in  1  synchronous, active-high reset.
- en  in  1  overlay enable; when 0, rgb passes through unchanged.
- hcount_in  in  11  horizontal pixel count.
- hsync_in  in  1  horizontal sync.
- hblnk_in  in  1  horizontal blanking.
- vcount_in  in  11  vertical line count.
- vsync_in  in  1  vertical sync.
- vblnk_in  in  1  vertical blanking.
- rgb_in  in  12  background colour.
- char_pixels  in  8  font ROM row; valid 1 pclk after char_yx/char_line; bit 7 is the leftmost pixel.
- char_yx  out  8  {row[3:0], col[3:0]} to char ROM; combinational.
- char_line  out  4  glyph row index to font ROM; combinational.
- hcount_out, hsync_out, hblnk_out, vcount_out, vsync_out, vblnk_out  out  11/1/1/11/1/1  timing signals delayed 2 pclk.
- rgb_out  out  12  composited colour, delayed 2 pclk.

Behaviour:
- Geometry:
  - rel_x = hcount_in - XPOS; rel_y = vcount_in - YPOS (11-bit, unsigned wrap).
  - in_box = (hcount_in >= XPOS) && (hcount_in < XPOS+128) && (vcount_in >= YPOS) && (vcount_in < YPOS+256).
- Address generation (stage 0, combinational):
  - char_yx = {rel_y[7:4], rel_x[6:3]}; char_line = rel_y[3:0].
  - Both are forced to 0 when !in_box.
- Stage 1 register: captures all timing inputs, rgb_in, en, in_box, and bitsel = rel_x[2:0].
- Pixel select (combinational at stage 1): pix = char_pixels[7 - bitsel_d1].
- Stage 2 register:
  - timing signals copied from stage 1.
  - rgb_out = 12'h000 if hblnk_d1 || vblnk_d1.
  - else TEXT_COLOR if en_d1 && in_box_d1 && pix.
  - else rgb_d1.
- Latency: exactly 2 pclk from any input to the matching *_out; no bubbles, one pixel per clock.
- Reset:
  - All stage-1 and stage-2 registers clear to 0, so every *_out and rgb_out reads 0 on the edge where rst is high.
  - Reset mid-frame: outputs go 0 on that edge. The first post-reset input appears at the outputs 2 pclk after rst deasserts; the intervening output is the cleared value 0.
- Boundaries:
  - hcount_in = XPOS-1 or XPOS+128 → outside the box; char_pixels is ignored.
  - rel_x wrap for hcount_in < XPOS is harmless because in_box gates it.
  - Blanking has priority over the text colour.
- en is not registered beyond pipeline alignment; toggling it takes effect on the pixel it accompanies.

Decomposition:
- Shared package (vga_pkg) constants:
  - CHAR_W = 8, CHAR_H = 16, TEXT_COLS = 16, TEXT_ROWS = 16.
  - HV_W = 11, RGB_W = 12.
- One sub-module: delay, a generic N-stage, WIDTH-bit register chain with synchronous reset. It carries the timing bundle {hcount, hsync, hblnk, vcount, vsync, vblnk} through 2 stages.

Test Plan:
- rst=1 for 3 cycles with arbitrary inputs → every *_out and rgb_out = 0. After release, outputs equal inputs from 2 cycles earlier.
- hcount_in=48, vcount_in=64 → char_yx=8'h00, char_line=0 same cycle. Drive char_pixels=8'h80 next cycle → rgb_out=12'hFFF and hcount_out=48 two cycles after the input.
- hcount_in=91, vcount_in=103 → char_yx=8'h25, char_line=7. char_pixels=8'h10 (bit 4 = 7-3) → rgb_out=12'hFFF. char_pixels=8'hEF → rgb_out=rgb_in (e.g. 12'h123).
- hcount_in=47, then 176, with vcount_in=100 and char_pixels=8'hFF → char_yx=0 and rgb_out=rgb_in delayed 2 for both.
- Inside box, pix=1, hblnk_in=1 → rgb_out=12'h000. Same pixel with en=0 and no blanking → rgb_out=rgb_in.
- Full-line sweep hcount 0..1055 at vcount=64 against a model of the glyph ROM → rgb_out matches the model on every pixel with constant 2-cycle alignment of hsync_out/hblnk_out.
